// File: rtl/pong_pkg.sv
// pong_pkg: types and constants shared by the pong score-keeping blocks.
//   state_e      - score keeper FSM states
//   SEG_0..SEG_9 - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    - all segments off
package pong_pkg;

   typedef enum logic [1:0] {
      SERVE     = 2'd0,
      PLAY      = 2'd1,
      GAME_OVER = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage : pong_pkg

// File: rtl/seven_seg.sv
// seven_seg: 4-bit value to active-low 7-segment decoder.
// Ports:
//   value_i - unsigned value; 0..9 shown as a digit, anything above is blank
//   seg_o   - segments {g,f,e,d,c,b,a}, active-low
module seven_seg
   import pong_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      seg_o = SEG_BLANK;
      case (value_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule : seven_seg

// File: rtl/score_keeper.sv
// score_keeper: keeps both players' scores, runs the serve/play/game-over
// FSM and drives the two score digits.
// Ports:
//   clk         - clock, shared with the ball stage
//   reset       - synchronous, active-low
//   score_left  - level: left player scored (may stay high several cycles)
//   score_right - level: right player scored
//   left_score  - left score 0..WIN_SCORE
//   right_score - right score 0..WIN_SCORE
//   hex1_d      - left digit, active-low {g,f,e,d,c,b,a}
//   hex0_d      - right digit, active-low
//   ball_hold   - 1 keeps the ball parked (serve delay and game over)
//   game_over   - 1 in GAME_OVER
//   winner      - 0 left won, 1 right won; valid while game_over = 1
module score_keeper
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_DELAY  = 3,
   parameter int BLINK_PERIOD = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       score_left,
   input  logic       score_right,
   output logic [3:0] left_score,
   output logic [3:0] right_score,
   output logic [6:0] hex1_d,
   output logic [6:0] hex0_d,
   output logic       ball_hold,
   output logic       game_over,
   output logic       winner
);

   localparam int SW = $clog2(SERVE_DELAY + 1);
   localparam int BW = $clog2(2 * BLINK_PERIOD);

   localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
   localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_DELAY);
   localparam logic [SW-1:0] SERVE_LAST = SW'(1);
   // One blink period covers a shown half and a blank half.
   localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_PERIOD);
   localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_PERIOD - 1);

   state_e        state_q, state_d;
   logic [3:0]    left_q, left_d;
   logic [3:0]    right_q, right_d;
   logic [SW-1:0] serve_cnt_q, serve_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          winner_q, winner_d;
   logic          sl_q, sr_q;

   logic          left_edge, right_edge;
   logic          blink_blank;
   logic [6:0]    seg_left, seg_right;

   assign left_edge  = score_left  & ~sl_q;
   assign right_edge = score_right & ~sr_q;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state_q     <= SERVE;
         left_q      <= '0;
         right_q     <= '0;
         serve_cnt_q <= SERVE_LOAD;
         blink_cnt_q <= '0;
         winner_q    <= 1'b0;
         sl_q        <= 1'b0;
         sr_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         left_q      <= left_d;
         right_q     <= right_d;
         serve_cnt_q <= serve_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         winner_q    <= winner_d;
         // Edge history tracks the inputs in every state, so a level held
         // across the serve delay is not seen as a fresh point afterwards.
         sl_q        <= score_left;
         sr_q        <= score_right;
      end
   end

   always_comb begin
      state_d     = state_q;
      left_d      = left_q;
      right_d     = right_q;
      serve_cnt_d = serve_cnt_q;
      blink_cnt_d = '0;
      winner_d    = winner_q;

      case (state_q)
         SERVE: begin
            if (serve_cnt_q == SERVE_LAST) begin
               state_d = PLAY;
            end else begin
               serve_cnt_d = serve_cnt_q - 1'b1;
            end
         end

         PLAY: begin
            // Simultaneous edges are a glitch: nothing changes.
            if (left_edge && !right_edge && left_q < WIN) begin
               left_d = left_q + 4'd1;
               if (left_d == WIN) begin
                  state_d  = GAME_OVER;
                  winner_d = 1'b0;
               end else begin
                  state_d     = SERVE;
                  serve_cnt_d = SERVE_LOAD;
               end
            end else if (right_edge && !left_edge && right_q < WIN) begin
               right_d = right_q + 4'd1;
               if (right_d == WIN) begin
                  state_d  = GAME_OVER;
                  winner_d = 1'b1;
               end else begin
                  state_d     = SERVE;
                  serve_cnt_d = SERVE_LOAD;
               end
            end
         end

         GAME_OVER: begin
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
         end

         default: state_d = SERVE;
      endcase
   end

   assign left_score  = left_q;
   assign right_score = right_q;
   assign ball_hold   = (state_q != PLAY);
   assign game_over   = (state_q == GAME_OVER);
   assign winner      = winner_q;

   // Second half of each blink period blanks the winner's digit.
   assign blink_blank = game_over && (blink_cnt_q >= BLINK_HALF);

   seven_seg u_seg_left  (.value_i(left_q),  .seg_o(seg_left));
   seven_seg u_seg_right (.value_i(right_q), .seg_o(seg_right));

   assign hex1_d = (blink_blank && !winner_q) ? SEG_BLANK : seg_left;
   assign hex0_d = (blink_blank &&  winner_q) ? SEG_BLANK : seg_right;

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed-vector bench for score_keeper with default
// parameters (WIN_SCORE 9, SERVE_DELAY 3, BLINK_PERIOD 2).
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       reset;
   logic       score_left;
   logic       score_right;
   logic [3:0] left_score;
   logic [3:0] right_score;
   logic [6:0] hex1_d;
   logic [6:0] hex0_d;
   logic       ball_hold;
   logic       game_over;
   logic       winner;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] D0    = 7'b1000000;
   localparam logic [6:0] D1    = 7'b1111001;
   localparam logic [6:0] D4    = 7'b0011001;
   localparam logic [6:0] D9    = 7'b0010000;
   localparam logic [6:0] BLANK = 7'b1111111;

   score_keeper dut (
      .clk        (clk),
      .reset      (reset),
      .score_left (score_left),
      .score_right(score_right),
      .left_score (left_score),
      .right_score(right_score),
      .hex1_d     (hex1_d),
      .hex0_d     (hex0_d),
      .ball_hold  (ball_hold),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle point pulse in PLAY, then wait out the serve delay.
   task automatic point(input logic left);
      if (left) score_left = 1'b1; else score_right = 1'b1;
      tick();
      score_left  = 1'b0;
      score_right = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      logic [6:0] blink_exp [6];
      blink_exp = '{D9, D9, BLANK, BLANK, D9, D9};

      reset       = 1'b0;
      score_left  = 1'b0;
      score_right = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_left",  left_score,  0);
      check("rst_right", right_score, 0);
      check("rst_hex1",  hex1_d, D0);
      check("rst_hex0",  hex0_d, D0);
      check("rst_hold",  ball_hold, 1);
      check("rst_go",    game_over, 0);
      check("rst_win",   winner, 0);

      // Serve delay after reset: hold for 3 cycles then PLAY
      reset = 1'b1;
      tick(); check("srv0_hold1", ball_hold, 1);
      tick(); check("srv0_hold2", ball_hold, 1);
      tick(); check("srv0_hold3", ball_hold, 0);
      check("srv0_go", game_over, 0);

      // Left level held high for 5 cycles counts once
      score_left = 1'b1;
      tick(); check("lvl_left", left_score, 1); check("lvl_hold_a", ball_hold, 1);
      tick(); check("lvl_hold_b", ball_hold, 1);
      tick(); check("lvl_hold_c", ball_hold, 1);
      tick(); check("lvl_play", ball_hold, 0); check("lvl_left_b", left_score, 1);
      tick(); check("lvl_left_c", left_score, 1);
      check("lvl_hex1", hex1_d, D1);
      check("lvl_hex0", hex0_d, D0);
      check("lvl_hold_d", ball_hold, 0);
      score_left = 1'b0;
      tick();

      // Simultaneous edges: glitch, nothing changes
      score_left  = 1'b1;
      score_right = 1'b1;
      tick(); tick();
      check("both_left",  left_score, 1);
      check("both_right", right_score, 0);
      check("both_hold",  ball_hold, 0);
      score_left  = 1'b0;
      score_right = 1'b0;
      tick();

      // Pulses during SERVE are ignored
      score_right = 1'b1;
      tick(); check("srv_right", right_score, 1);
      score_right = 1'b0;
      tick();
      score_left = 1'b1;
      tick();                     // SERVE, left edge ignored
      score_left  = 1'b0;
      score_right = 1'b1;
      tick();                     // last SERVE cycle, right edge ignored
      score_right = 1'b0;
      check("srv_ign_left",  left_score, 1);
      check("srv_ign_right", right_score, 1);
      check("srv_ign_play",  ball_hold, 0);
      tick();
      check("srv_ign_left_b",  left_score, 1);
      check("srv_ign_right_b", right_score, 1);

      // Right player to 8 points
      for (int i = 0; i < 7; i++) point(1'b0);
      check("r8_right", right_score, 8);
      check("r8_hold",  ball_hold, 0);
      check("r8_go",    game_over, 0);

      // Ninth point: game over, right wins, winner digit blinks
      score_right = 1'b1;
      tick();
      score_right = 1'b0;
      check("go_right", right_score, 9);
      check("go_flag",  game_over, 1);
      check("go_win",   winner, 1);
      check("go_hold",  ball_hold, 1);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("blink_hex0_%0d", i), hex0_d, blink_exp[i]);
         check($sformatf("blink_hex1_%0d", i), hex1_d, D1);
         tick();
      end
      // Further points are frozen out
      score_right = 1'b1;
      tick();
      score_right = 1'b0;
      tick();
      check("frz_right", right_score, 9);
      check("frz_left",  left_score, 1);
      check("frz_go",    game_over, 1);

      // Fresh game, left to 4, reset mid-PLAY
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("new_go",    game_over, 0);
      check("new_right", right_score, 0);
      check("new_hex0",  hex0_d, D0);
      for (int i = 0; i < 4; i++) point(1'b1);
      check("l4_left", left_score, 4);
      check("l4_hex1", hex1_d, D4);
      check("l4_hold", ball_hold, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_left",  left_score, 0);
      check("mid_right", right_score, 0);
      check("mid_hold",  ball_hold, 1);
      check("mid_hex1",  hex1_d, D0);
      check("mid_go",    game_over, 0);
      repeat (3) tick();
      check("mid_play", ball_hold, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_score_keeper
